// File: rtl/dp_mon_pkg.sv
// Shared types and default constants for the double-pulse feedback monitor.
package dp_mon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_P1,
    PULSE1,
    GAP,
    PULSE2,
    DONE
  } dp_state_e;

  localparam int unsigned DEF_CNT_W    = 24;
  localparam int unsigned DEF_TIMEOUT  = 200_000_000;
  localparam int unsigned DEF_DEAD_MIN = 200;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by an edge register; the level and the
// rise/fall strobes come out of the same stage, so they stay aligned.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic lvl_q;
  logic rise_q;
  logic fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      lvl_q  <= sync_q;
      rise_q <= sync_q & ~lvl_q;
      fall_q <= ~sync_q & lvl_q;
    end
  end

  assign s_o    = lvl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/double_pulse_monitor.sv
// Measures pulse1 / gap / pulse2 widths of the high-side gate feedback and
// flags overlap, dead-time and timeout faults; one record per accepted arm.
module double_pulse_monitor
  import dp_mon_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
  parameter int unsigned DEAD_MIN = DEF_DEAD_MIN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             fb_hi,
  input  logic             fb_lo,
  output logic             busy,
  output logic             meas_valid,
  output logic [CNT_W-1:0] t_pulse1,
  output logic [CNT_W-1:0] t_gap,
  output logic [CNT_W-1:0] t_pulse2,
  output logic             err_overlap,
  output logic             err_dead,
  output logic             err_timeout
);

  localparam int unsigned RES_W = $clog2(TIMEOUT + 1);
  localparam int unsigned DW    = $clog2(DEAD_MIN + 1);

  logic hi_s, hi_rise, hi_fall;
  logic lo_s, lo_rise, lo_fall;

  sync_edge u_sync_hi (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (fb_hi),
    .s_o    (hi_s),
    .rise_o (hi_rise),
    .fall_o (hi_fall)
  );

  sync_edge u_sync_lo (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (fb_lo),
    .s_o    (lo_s),
    .rise_o (lo_rise),
    .fall_o (lo_fall)
  );

  dp_state_e        state_q;
  logic [RES_W-1:0] res_q;
  logic [DW-1:0]    hi_low_q, lo_low_q;
  logic [CNT_W-1:0] t_pulse1_q, t_gap_q, t_pulse2_q;
  logic             busy_q, meas_valid_q;
  logic             err_overlap_q, err_dead_q, err_timeout_q;

  logic active, overlap, timeout, abort, dead_viol, leave;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + CNT_W'(1);
  endfunction

  always_comb begin
    active    = (state_q != IDLE) && (state_q != DONE);
    overlap   = active && hi_s && lo_s;
    timeout   = active && (res_q == RES_W'(TIMEOUT - 1));
    abort     = overlap || timeout;
    dead_viol = active && ((hi_rise && (lo_low_q < DW'(DEAD_MIN))) ||
                           (lo_rise && (hi_low_q < DW'(DEAD_MIN))));
    unique case (state_q)
      IDLE:          leave = arm;
      WAIT_P1, GAP:  leave = hi_rise;
      PULSE1,PULSE2: leave = hi_fall;
      DONE:          leave = 1'b1;
      default:       leave = 1'b0;
    endcase
    leave = leave || abort;
  end

  // Low-time counters restart at 1 on the falling edge and saturate at DEAD_MIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_low_q <= '0;
      lo_low_q <= '0;
    end else begin
      if (hi_s)                          hi_low_q <= '0;
      else if (hi_fall)                  hi_low_q <= DW'(1);
      else if (hi_low_q < DW'(DEAD_MIN)) hi_low_q <= hi_low_q + DW'(1);
      if (lo_s)                          lo_low_q <= '0;
      else if (lo_fall)                  lo_low_q <= DW'(1);
      else if (lo_low_q < DW'(DEAD_MIN)) lo_low_q <= lo_low_q + DW'(1);
    end
  end

  // Width counters advance as usual in an abort cycle; abort only redirects the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      res_q         <= '0;
      t_pulse1_q    <= '0;
      t_gap_q       <= '0;
      t_pulse2_q    <= '0;
      busy_q        <= 1'b0;
      meas_valid_q  <= 1'b0;
      err_overlap_q <= 1'b0;
      err_dead_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      meas_valid_q <= 1'b0;
      res_q        <= (!active || leave) ? '0 : res_q + RES_W'(1);
      if (dead_viol) err_dead_q <= 1'b1;

      unique case (state_q)
        IDLE: if (arm) begin
          state_q       <= WAIT_P1;
          busy_q        <= 1'b1;
          t_pulse1_q    <= '0;
          t_gap_q       <= '0;
          t_pulse2_q    <= '0;
          err_overlap_q <= 1'b0;
          err_dead_q    <= 1'b0;
          err_timeout_q <= 1'b0;
        end
        WAIT_P1: if (hi_rise) begin
          t_pulse1_q <= CNT_W'(1);
          state_q    <= PULSE1;
        end
        PULSE1: if (hi_fall) begin
          t_gap_q <= CNT_W'(1);
          state_q <= GAP;
        end else begin
          t_pulse1_q <= sat_inc(t_pulse1_q);
        end
        GAP: if (hi_rise) begin
          t_pulse2_q <= CNT_W'(1);
          state_q    <= PULSE2;
        end else begin
          t_gap_q <= sat_inc(t_gap_q);
        end
        PULSE2: if (hi_fall) begin
          state_q <= DONE;
        end else begin
          t_pulse2_q <= sat_inc(t_pulse2_q);
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (abort) state_q <= DONE;
      if (overlap) err_overlap_q <= 1'b1;
      if (timeout) err_timeout_q <= 1'b1;
      if (abort || (state_q == PULSE2 && hi_fall)) begin
        meas_valid_q <= 1'b1;
        busy_q       <= 1'b0;
      end
    end
  end

  assign busy        = busy_q;
  assign meas_valid  = meas_valid_q;
  assign t_pulse1    = t_pulse1_q;
  assign t_gap       = t_gap_q;
  assign t_pulse2    = t_pulse2_q;
  assign err_overlap = err_overlap_q;
  assign err_dead    = err_dead_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: doc/double_pulse_monitor.md
# double_pulse_monitor

Measures the gate-drive feedback of a double-pulse test. It captures the first pulse width, the inter-pulse gap and the second pulse width of the high-side feedback. It also checks high/low-side interlock (overlap and dead time) and reports one result record per armed test. It sits beside the double-pulse generator on the test board and closes the loop on the K1/K2 drive signals through the driver's feedback pins.

## Interface
Parameters:
- CNT_W, 24: width of all measurement counters.
- TIMEOUT, 200_000_000: max cycles allowed in any waiting/measuring state (5 s at 40 MHz).
- DEAD_MIN, 200: min cycles fb_lo must be low before fb_hi rises, and fb_hi low before fb_lo rises.

Ports:
- clk  in  1  system clock, 40 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- arm  in  1  start one measurement; sampled only in IDLE.
- fb_hi  in  1  asynchronous high-side gate feedback (K1 path).
- fb_lo  in  1  asynchronous low-side gate feedback (K2 path).
- busy  out  1  high from accepted arm until meas_valid.
- meas_valid  out  1  single-cycle strobe; record outputs valid.
- t_pulse1  out  CNT_W  cycles fb_hi high, first pulse.
- t_gap  out  CNT_W  cycles fb_hi low between pulses.
- t_pulse2  out  CNT_W  cycles fb_hi high, second pulse.
- err_overlap  out  1  fb_hi and fb_lo both high at some cycle.
- err_dead  out  1  dead-time violation.
- err_timeout  out  1  TIMEOUT expired.

## Operation
- Inputs pass through a 2-FF synchronizer and rise/fall detector. All logic uses the synchronized values hi_s and lo_s.
- FSM states:
  - IDLE: arm=1 goes to WAIT_P1, clears counters and error flags, sets busy.
  - WAIT_P1: rise of hi_s goes to PULSE1.
  - PULSE1: counts t_pulse1 starting at 1 on the rise cycle. Fall of hi_s goes to GAP.
  - GAP: counts t_gap. Rise of hi_s goes to PULSE2.
  - PULSE2: counts t_pulse2. Fall of hi_s goes to DONE.
  - DONE: one cycle. Pulses meas_valid, clears busy, returns to IDLE.
- Overlap: hi_s & lo_s in any non-IDLE state sets err_overlap and moves to DONE next cycle.
- Dead time:
  - lo_low_cnt counts consecutive lo_s=0 cycles, saturating at DEAD_MIN.
  - hi_low_cnt counts consecutive hi_s=0 cycles, saturating at DEAD_MIN.
  - A hi_s rise while lo_low_cnt<DEAD_MIN sets err_dead.
  - A lo_s rise while hi_low_cnt<DEAD_MIN sets err_dead.
  - err_dead does not abort the measurement.
- Timeout:
  - A state-residency counter, reset on every state change, moves to DONE with err_timeout=1 when it reaches TIMEOUT.
  - On timeout, record fields keep the partial counts.
- Width counters saturate at 2^CNT_W-1 and do not wrap.
- Record fields and error flags hold their values until the next accepted arm.
- arm outside IDLE is ignored.

## Timing
- Reset values:
  - busy=0, meas_valid=0, all t_* = 0, all err_* = 0, FSM=IDLE.
  - Synchronizer flops are 0.
- Input-to-state latency is 2 cycles (synchronizer) plus 1 cycle (edge register). The latency is identical on both edges, so measured widths are exact in cycles.
- meas_valid asserts 1 cycle after the PULSE2→DONE transition. For overlap or timeout it asserts 1 cycle after the detecting cycle.
- arm accepted at cycle n: busy=1 at n+1.
- When a rise and a fall of hi_s both fall within one synchronized cycle, the fall is taken first. A 1-cycle glitch therefore yields a pulse width of 1.
- Overlap detected in the same cycle as a counted edge: the overlap abort wins, and the counter still records that cycle.
- rst_n assertion mid-measurement: immediate return to reset values. No meas_valid is issued.

## Structure
- Package dp_mon_pkg holds:
  - state enum (IDLE, WAIT_P1, PULSE1, GAP, PULSE2, DONE);
  - default parameter constants (CNT_W, TIMEOUT, DEAD_MIN).
- Sub-module sync_edge: 2-FF synchronizer plus registered rise/fall outputs with async active-low reset. Instantiated once for fb_hi and once for fb_lo.
- Top holds the FSM, the width, dead and residency counters, and the output registers.

## Test plan
- Nominal: arm, then fb_hi high 4000 / low 800 / high 1200, with fb_lo complementary and 280-cycle dead gaps. Expect t_pulse1=4000, t_gap=800, t_pulse2=1200, all errors 0, one meas_valid.
- Overlap: as nominal, but fb_lo rises 100 cycles into pulse 1. Expect err_overlap=1, meas_valid within 3 cycles of the overlap, t_pulse1=101±0.
- Dead time: fb_lo falls 50 cycles before the fb_hi rise, with DEAD_MIN=200. Expect err_dead=1 and full widths still reported.
- Timeout: set TIMEOUT=1000 and leave fb_hi low after arm. Expect meas_valid with err_timeout=1 and all t_*=0, 1000 cycles after WAIT_P1 entry.
- Reset mid-op: assert rst_n low during GAP. Expect all outputs 0 and busy=0 immediately. After release, a new nominal test measures correctly.
- arm re-asserted during PULSE1: ignored, record unchanged. Saturation check: CNT_W=8 with a 300-cycle pulse gives t_pulse1=255.
